// File: rtl/contador_param.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// wrap/saturate boundary mode, cascade terminal count and sticky overflow.
module contador_param #(
    parameter int WIDTH    = 8,
    parameter int MAX      = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    input  logic             Up,
    output logic [WIDTH-1:0] Q,
    output logic             Fim,
    output logic             Zero,
    output logic             Tc,
    output logic             Ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic             at_max;
    logic             at_min;
    logic             at_bound;
    logic [WIDTH-1:0] d_clamp;
    logic [WIDTH-1:0] q_step;

    assign at_max   = (Q == MAXV);
    assign at_min   = (Q == '0);
    assign at_bound = Up ? at_max : at_min;
    assign Fim      = at_max;
    assign Zero     = at_min;

    // Only a wrapping counter can carry into the next stage.
    assign Tc = En & ~Load & ~Clear & ~Reset & at_bound & ~SATURATE;

    assign d_clamp = (D > MAXV) ? MAXV : D;

    always_comb begin
        q_step = Q;
        if (Up) begin
            if (!at_max)
                q_step = Q + WIDTH'(1);
            else if (!SATURATE)
                q_step = '0;
        end else begin
            if (!at_min)
                q_step = Q - WIDTH'(1);
            else if (!SATURATE)
                q_step = MAXV;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            Q   <= '0;
            Ovf <= 1'b0;
        end else if (Load) begin
            Q <= d_clamp;
        end else if (En) begin
            Q <= q_step;
            if (at_bound)
                Ovf <= 1'b1;
        end
    end

endmodule
